bayer_demosaic_ctrl: RTL

//  Frame/line sequencer for the RAW8->RGB888 demosaic path. Tracks the vsync/href stream, counts pixels and lines,
//  and issues the per-pixel Bayer phase select, with the sensor's Bayer pattern applied as a parity offset.

---
 rtl/bayer_demosaic_ctrl_if.sv | 23 ++
 rtl/bayer_demosaic_ctrl.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/bayer_demosaic_ctrl_if.sv
// Video timing stream between the matrix generator and the demosaic sequencer:
// raw vsync/href in, gated timing plus Bayer phase and pixel/line indices out.
interface bayer_demosaic_ctrl_if;
    logic        in_vsync;
    logic        in_href;
    logic        out_vsync;
    logic        out_href;
    logic [1:0]  bayer_phase;
    logic [10:0] pix_cnt;
    logic [10:0] line_cnt;
    logic        frame_start;
    logic        frame_end;

    modport master (
        output in_vsync, in_href,
        input  out_vsync, out_href, bayer_phase, pix_cnt, line_cnt, frame_start, frame_end
    );

    modport slave (
        input  in_vsync, in_href,
        output out_vsync, out_href, bayer_phase, pix_cnt, line_cnt, frame_start, frame_end
    );
endinterface

// File: rtl/bayer_demosaic_ctrl.sv
// Frame/line sequencer for the RAW8->RGB888 demosaic path: tracks vsync/href, issues
// per-pixel Bayer phase, latches config per frame, gates bad geometry and flags errors.
module bayer_demosaic_ctrl #(
    parameter int IMG_HDISP = 640,
    parameter int IMG_VDISP = 480
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [1:0]                  cfg_pattern,
    input  logic                        cfg_enable,
    input  logic                        err_clr,
    bayer_demosaic_ctrl_if.slave        vid_if,
    output logic                        demosaic_en,
    output logic [15:0]                 frame_cnt,
    output logic                        err_short_line,
    output logic                        err_long_line,
    output logic                        err_line_count
);

    localparam logic [10:0] HDISP = 11'(IMG_HDISP);
    localparam logic [10:0] VDISP = 11'(IMG_VDISP);

    typedef enum logic [1:0] {SYNC, IDLE, HBLANK, LINE} state_t;

    state_t      state_q;
    logic [1:0]  pat_q;
    logic        en_q;
    logic [10:0] nk_q;
    logic [10:0] line_q;
    logic        out_vsync_q;
    logic        out_href_q;
    logic [1:0]  phase_q;
    logic [10:0] pix_cnt_q;
    logic [10:0] line_cnt_q;
    logic        frame_start_q;
    logic        frame_end_q;
    logic [15:0] frame_cnt_q;
    logic        err_short_q;
    logic        err_long_q;
    logic        err_lcnt_q;

    logic        active_d;
    logic        acc_d;
    logic        close_d;
    logic        fend_d;
    logic        pass_d;
    logic [10:0] pix_idx_d;
    logic [10:0] lines_d;

    function automatic logic [10:0] sat_inc(input logic [10:0] v);
        return (v == '1) ? v : v + 11'd1;
    endfunction

    // A line closes on href fall or on vsync fall mid-line; the latter also ends the frame.
    always_comb begin
        active_d  = (state_q == HBLANK) || (state_q == LINE);
        acc_d     = active_d && vid_if.in_vsync && vid_if.in_href;
        pix_idx_d = (state_q == LINE) ? nk_q : '0;
        close_d   = (state_q == LINE) && !(vid_if.in_vsync && vid_if.in_href);
        fend_d    = active_d && !vid_if.in_vsync;
        lines_d   = close_d ? sat_inc(line_q) : line_q;
        pass_d    = acc_d && (pix_idx_d < HDISP) && (line_q < VDISP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= SYNC;
            pat_q         <= '0;
            en_q          <= 1'b0;
            nk_q          <= '0;
            line_q        <= '0;
            out_vsync_q   <= 1'b0;
            out_href_q    <= 1'b0;
            phase_q       <= '0;
            pix_cnt_q     <= '0;
            line_cnt_q    <= '0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            frame_cnt_q   <= '0;
            err_short_q   <= 1'b0;
            err_long_q    <= 1'b0;
            err_lcnt_q    <= 1'b0;
        end else begin
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            out_vsync_q   <= (state_q != SYNC) && vid_if.in_vsync;
            out_href_q    <= pass_d;
            pix_cnt_q     <= pass_d ? pix_idx_d : '0;
            phase_q       <= pass_d ? {line_q[0] ^ pat_q[1], pix_idx_d[0] ^ pat_q[0]} : '0;
            if (acc_d) begin
                nk_q       <= sat_inc(pix_idx_d);
                line_cnt_q <= line_q;
            end
            if (close_d) begin
                line_q <= lines_d;
            end
            err_short_q <= (close_d && (nk_q < HDISP)) || (err_short_q && !err_clr);
            err_long_q  <= (acc_d && (pix_idx_d >= HDISP)) || (err_long_q && !err_clr);
            err_lcnt_q  <= (fend_d && (lines_d != VDISP)) || (err_lcnt_q && !err_clr);
            if (fend_d) begin
                frame_end_q <= 1'b1;
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            case (state_q)
                SYNC:    if (!vid_if.in_vsync) state_q <= IDLE;
                IDLE: begin
                    if (vid_if.in_vsync) begin
                        state_q       <= HBLANK;
                        pat_q         <= cfg_pattern;
                        en_q          <= cfg_enable;
                        line_q        <= '0;
                        line_cnt_q    <= '0;
                        frame_start_q <= 1'b1;
                    end
                end
                HBLANK: begin
                    if (!vid_if.in_vsync)    state_q <= IDLE;
                    else if (vid_if.in_href) state_q <= LINE;
                end
                LINE: begin
                    if (!vid_if.in_vsync)     state_q <= IDLE;
                    else if (!vid_if.in_href) state_q <= HBLANK;
                end
                default: state_q <= SYNC;
            endcase
        end
    end

    assign vid_if.out_vsync   = out_vsync_q;
    assign vid_if.out_href    = out_href_q;
    assign vid_if.bayer_phase = phase_q;
    assign vid_if.pix_cnt     = pix_cnt_q;
    assign vid_if.line_cnt    = line_cnt_q;
    assign vid_if.frame_start = frame_start_q;
    assign vid_if.frame_end   = frame_end_q;
    assign demosaic_en        = en_q;
    assign frame_cnt          = frame_cnt_q;
    assign err_short_line     = err_short_q;
    assign err_long_line      = err_long_q;
    assign err_line_count     = err_lcnt_q;

endmodule
